// File: rtl/trace_checker.sv
// Golden-trace commit checker for the single-cycle CPU.
// Prefetches golden entries from a synchronous ROM into a small FIFO, releases the CPU
// through `run`, and compares each commit against the FIFO head. On the first divergence
// it stops and holds an error record.
// Optional build macro: TRACE_CHECK_REGWRITE_EN adds the register-write comparison
// (golden entry becomes {pc, inst, we, waddr[4:0], wdata}, 102 bits).
module trace_checker #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DEPTH   = 4,
  parameter logic [31:0] PC_BASE = 32'h0040_0000,
`ifdef TRACE_CHECK_REGWRITE_EN
  localparam int unsigned GW     = 102
`else
  localparam int unsigned GW     = 64
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] trace_len,
  output logic          g_rd,
  output logic [AW-1:0] g_addr,
  input  logic [GW-1:0] g_data,
  input  logic          c_valid,
  input  logic [31:0]   c_pc,
  input  logic [31:0]   c_inst,
  input  logic [31:0]   c_wdata,
  input  logic          c_we,
  input  logic [4:0]    c_waddr,
  output logic          run,
  output logic          done,
  output logic          pass,
  output logic [1:0]    err_code,
  output logic [AW-1:0] err_index,
  output logic [31:0]   err_got_pc,
  output logic [31:0]   err_got_inst,
  output logic [AW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = PW + 1;
  localparam logic [OW:0] DepthP = (OW + 1)'(DEPTH);

  localparam logic [1:0] ErrNone      = 2'd0;
  localparam logic [1:0] ErrPcInst    = 2'd1;
  localparam logic [1:0] ErrRegWr     = 2'd2;
  localparam logic [1:0] ErrUnderflow = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StRun,
    StPass,
    StFail
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] issued_q, issued_d;
  logic [AW-1:0] count_q, count_d;
  logic          in_flight_q, in_flight_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [GW-1:0] mem_q [DEPTH];
  logic [GW-1:0] mem_d [DEPTH];
  logic [1:0]    err_code_q, err_code_d;
  logic [AW-1:0] err_index_q, err_index_d;
  logic [31:0]   err_got_pc_q, err_got_pc_d;
  logic [31:0]   err_got_inst_q, err_got_inst_d;
  logic          run_q, run_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  logic          fetch_en;
  logic          push;
  logic          pop;
  logic          clear;
  logic          rd_req;
  logic [OW:0]   pending;
  logic [AW-1:0] count_inc;
  logic [GW-1:0] head;
  logic [31:0]   head_pc;
  logic [31:0]   head_inst;
  logic [31:0]   pc_off;
  logic          pc_inst_mismatch;
  logic          reg_mismatch;

  assign head      = mem_q[rd_ptr_q];
  assign head_pc   = head[GW-1 -: 32];
  assign head_inst = head[GW-33 -: 32];
  // PC offset wraps modulo 2^32 by construction of the 32-bit subtraction.
  assign pc_off    = c_pc - PC_BASE;
  assign pc_inst_mismatch = (pc_off != head_pc) || (c_inst != head_inst);

`ifdef TRACE_CHECK_REGWRITE_EN
  logic        head_we;
  logic [4:0]  head_waddr;
  logic [31:0] head_wdata;
  logic        eff_golden;
  logic        eff_commit;

  assign head_we    = head[37];
  assign head_waddr = head[36:32];
  assign head_wdata = head[31:0];
  // Writes to x0 are architecturally invisible, so they count as no write at all.
  assign eff_golden = head_we && (head_waddr != 5'd0);
  assign eff_commit = c_we && (c_waddr != 5'd0);
  assign reg_mismatch = (eff_golden != eff_commit) ||
                        (eff_golden && eff_commit &&
                         ((head_waddr != c_waddr) || (head_wdata != c_wdata)));
`else
  logic unused_regwrite;
  assign unused_regwrite = ^{c_we, c_waddr, c_wdata};
  assign reg_mismatch    = 1'b0;
`endif

  // Prefetch only while a run is being filled or checked; returning data is dropped otherwise.
  assign fetch_en  = (state_q == StFill) || (state_q == StRun);
  assign pending   = {1'b0, occ_q} + {{OW{1'b0}}, in_flight_q};
  assign rd_req    = fetch_en && (issued_q < len_q) && (pending < DepthP);
  assign push      = in_flight_q && fetch_en;
  assign count_inc = count_q + AW'(1);

  // Next-state, prefetch and compare logic.
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    issued_d       = issued_q + AW'(rd_req);
    count_d        = count_q;
    in_flight_d    = rd_req;
    err_code_d     = err_code_q;
    err_index_d    = err_index_q;
    err_got_pc_d   = err_got_pc_q;
    err_got_inst_d = err_got_inst_q;
    pop            = 1'b0;
    clear          = 1'b0;

    unique case (state_q)
      StIdle, StPass, StFail: begin
        if (start) begin
          clear          = 1'b1;
          len_d          = trace_len;
          issued_d       = '0;
          count_d        = '0;
          in_flight_d    = 1'b0;
          err_code_d     = ErrNone;
          err_index_d    = '0;
          err_got_pc_d   = '0;
          err_got_inst_d = '0;
          state_d        = (trace_len == '0) ? StPass : StFill;
        end
      end
      StFill: begin
        if ((occ_q >= OW'(2)) || (AW'(occ_q) == len_q)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (c_valid) begin
          if (occ_q == '0) begin
            err_code_d = ErrUnderflow;
          end else if (pc_inst_mismatch) begin
            err_code_d = ErrPcInst;
          end else if (reg_mismatch) begin
            err_code_d = ErrRegWr;
          end else begin
            pop     = 1'b1;
            count_d = count_inc;
            if (count_inc == len_q) begin
              state_d = StPass;
            end
          end
          if (!pop) begin
            err_index_d    = count_q;
            err_got_pc_d   = c_pc;
            err_got_inst_d = c_inst;
            state_d        = StFail;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    run_d  = (state_d == StRun);
    done_d = (state_d == StPass) || (state_d == StFail);
    pass_d = (state_d == StPass);
  end

  // FIFO pointer, occupancy and storage update; a push and pop together keep occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = g_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      occ_d = occ_q + OW'(push) - OW'(pop);
    end
  end

  // Control state and registered status, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StIdle;
      len_q          <= '0;
      issued_q       <= '0;
      count_q        <= '0;
      in_flight_q    <= 1'b0;
      occ_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      err_code_q     <= ErrNone;
      err_index_q    <= '0;
      err_got_pc_q   <= '0;
      err_got_inst_q <= '0;
      run_q          <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      issued_q       <= issued_d;
      count_q        <= count_d;
      in_flight_q    <= in_flight_d;
      occ_q          <= occ_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      err_code_q     <= err_code_d;
      err_index_q    <= err_index_d;
      err_got_pc_q   <= err_got_pc_d;
      err_got_inst_q <= err_got_inst_d;
      run_q          <= run_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
    end
  end

  // FIFO storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign g_rd         = rd_req;
  assign g_addr       = issued_q;
  assign run          = run_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_code     = err_code_q;
  assign err_index    = err_index_q;
  assign err_got_pc   = err_got_pc_q;
  assign err_got_inst = err_got_inst_q;
  assign count        = count_q;

endmodule

// File: tb/tb_trace_checker.sv
// Directed bench for trace_checker: main instance with the default FIFO depth and a
// second, shallow (DEPTH=2) instance used to provoke a FIFO underflow.
module tb_trace_checker;

  localparam int unsigned AW      = 16;
  localparam logic [31:0] PC_BASE = 32'h0040_0000;
  localparam logic [31:0] INST0   = 32'h2000_0000;
`ifdef TRACE_CHECK_REGWRITE_EN
  localparam int unsigned GW = 102;
`else
  localparam int unsigned GW = 64;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          start2;
  logic [AW-1:0] trace_len;
  logic          c_valid;
  logic [31:0]   c_pc;
  logic [31:0]   c_inst;
  logic [31:0]   c_wdata;
  logic          c_we;
  logic [4:0]    c_waddr;

  logic          g_rd, g_rd2;
  logic [AW-1:0] g_addr, g_addr2;
  logic [GW-1:0] g_data, g_data2;
  logic          run, run2, done, done2, pass, pass2;
  logic [1:0]    err_code, err_code2;
  logic [AW-1:0] err_index, err_index2, count, count2;
  logic [31:0]   err_got_pc, err_got_pc2, err_got_inst, err_got_inst2;

  logic [GW-1:0] rom [8];
  int            rd_cnt = 0;
  int            rd_base;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  trace_checker #(.AW(AW), .DEPTH(4), .PC_BASE(PC_BASE)) u_dut (
    .clk(clk), .rst(rst), .start(start), .trace_len(trace_len),
    .g_rd(g_rd), .g_addr(g_addr), .g_data(g_data),
    .c_valid(c_valid), .c_pc(c_pc), .c_inst(c_inst), .c_wdata(c_wdata),
    .c_we(c_we), .c_waddr(c_waddr),
    .run(run), .done(done), .pass(pass), .err_code(err_code), .err_index(err_index),
    .err_got_pc(err_got_pc), .err_got_inst(err_got_inst), .count(count)
  );

  trace_checker #(.AW(AW), .DEPTH(2), .PC_BASE(PC_BASE)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .trace_len(trace_len),
    .g_rd(g_rd2), .g_addr(g_addr2), .g_data(g_data2),
    .c_valid(c_valid), .c_pc(c_pc), .c_inst(c_inst), .c_wdata(c_wdata),
    .c_we(c_we), .c_waddr(c_waddr),
    .run(run2), .done(done2), .pass(pass2), .err_code(err_code2), .err_index(err_index2),
    .err_got_pc(err_got_pc2), .err_got_inst(err_got_inst2), .count(count2)
  );

  // Synchronous golden ROMs: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (g_rd) g_data <= rom[g_addr[2:0]];
    if (g_rd2) g_data2 <= rom[g_addr2[2:0]];
    if (g_rd) rd_cnt <= rd_cnt + 1;
  end

  function automatic logic [GW-1:0] ent(input logic [31:0] pc, input logic [31:0] inst);
`ifdef TRACE_CHECK_REGWRITE_EN
    return {pc, inst, 1'b0, 5'd0, 32'd0};
`else
    return {pc, inst};
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [AW-1:0] len);
    trace_len = len;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 20 && !run; i++) step();
    chk("run_rise", {63'd0, run}, 64'd1);
  endtask

  task automatic commit(input int k, input logic [31:0] pc);
    c_valid = 1'b1;
    c_pc    = pc;
    c_inst  = INST0 + 32'(k);
    step();
    c_valid = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) rom[k] = ent(32'(4 * k), INST0 + 32'(k));
    rst = 1'b0; start = 1'b0; start2 = 1'b0; trace_len = '0;
    c_valid = 1'b0; c_pc = '0; c_inst = '0; c_wdata = '0; c_we = 1'b0; c_waddr = '0;
    step(); step();
    chk("rst_run", {63'd0, run}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_pass", {63'd0, pass}, 64'd0);
    chk("rst_grd", {63'd0, g_rd}, 64'd0);
    chk("rst_gaddr", 64'(g_addr), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_err", 64'(err_code), 64'd0);
    rst = 1'b1;
    step();

    // Matching trace of five commits, back to back.
    rd_base = rd_cnt;
    do_start(16'd5);
    chk("t1_fill_done", {63'd0, done}, 64'd0);
    wait_run();
    for (int k = 0; k < 5; k++) commit(k, PC_BASE + 32'(4 * k));
    chk("t1_done", {63'd0, done}, 64'd1);
    chk("t1_pass", {63'd0, pass}, 64'd1);
    chk("t1_count", 64'(count), 64'd5);
    chk("t1_run", {63'd0, run}, 64'd0);
    chk("t1_err", 64'(err_code), 64'd0);
    chk("t1_reads", 64'(rd_cnt - rd_base), 64'd5);

    // PC divergence on the third commit.
    do_start(16'd5);
    wait_run();
    commit(0, PC_BASE);
    commit(1, PC_BASE + 32'd4);
    chk("t2_run_before", {63'd0, run}, 64'd1);
    commit(2, 32'h0040_0010);
    chk("t2_run_fall", {63'd0, run}, 64'd0);
    chk("t2_code", 64'(err_code), 64'd1);
    chk("t2_index", 64'(err_index), 64'd2);
    chk("t2_got_pc", 64'(err_got_pc), 64'h0040_0010);
    chk("t2_got_inst", 64'(err_got_inst), 64'(INST0 + 32'd2));
    chk("t2_count", 64'(count), 64'd2);
    chk("t2_done", {63'd0, done}, 64'd1);
    chk("t2_pass", {63'd0, pass}, 64'd0);
    commit(3, PC_BASE + 32'd12);
    chk("t2_ignored", 64'(count), 64'd2);

`ifdef TRACE_CHECK_REGWRITE_EN
    // Register-write mismatch, then a write to x0 whose data must not matter.
    rom[0] = {32'd0, INST0, 1'b1, 5'd8, 32'd5};
    c_we = 1'b1; c_waddr = 5'd8; c_wdata = 32'd6;
    do_start(16'd1);
    wait_run();
    commit(0, PC_BASE);
    chk("t3_code", 64'(err_code), 64'd2);
    chk("t3_pass", {63'd0, pass}, 64'd0);
    rom[0] = {32'd0, INST0, 1'b1, 5'd0, 32'd5};
    c_waddr = 5'd0;
    do_start(16'd1);
    wait_run();
    commit(0, PC_BASE);
    chk("t3_x0_pass", {63'd0, pass}, 64'd1);
    chk("t3_x0_code", 64'(err_code), 64'd0);
    rom[0] = ent(32'd0, INST0);
    c_we = 1'b0; c_waddr = 5'd0; c_wdata = 32'd0;
`endif

    // len=3 with four commits held back to back: the fourth lands after run drops.
    do_start(16'd3);
    wait_run();
    for (int k = 0; k < 3; k++) commit(k, PC_BASE + 32'(4 * k));
    chk("t4_pass", {63'd0, pass}, 64'd1);
    chk("t4_count", 64'(count), 64'd3);
    commit(3, PC_BASE + 32'd12);
    chk("t4_ignored", 64'(count), 64'd3);
    chk("t4_err", 64'(err_code), 64'd0);

    // Shallow FIFO drains under continuous commits: third commit underflows.
    trace_len = 16'd5;
    start2    = 1'b1;
    step();
    start2    = 1'b0;
    for (int i = 0; i < 20 && !run2; i++) step();
    chk("t5_run2", {63'd0, run2}, 64'd1);
    for (int k = 0; k < 3; k++) commit(k, PC_BASE + 32'(4 * k));
    chk("t5_code", 64'(err_code2), 64'd3);
    chk("t5_index", 64'(err_index2), 64'd2);
    chk("t5_count", 64'(count2), 64'd2);
    chk("t5_got_pc", 64'(err_got_pc2), 64'(PC_BASE + 32'd8));
    chk("t5_pass", {63'd0, pass2}, 64'd0);
    chk("t5_done", {63'd0, done2}, 64'd1);

    // Empty trace goes straight to PASS without any ROM reads.
    rd_base = rd_cnt;
    do_start(16'd0);
    chk("t6_pass", {63'd0, pass}, 64'd1);
    chk("t6_done", {63'd0, done}, 64'd1);
    chk("t6_run", {63'd0, run}, 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    step(); step(); step();
    chk("t6_run_later", {63'd0, run}, 64'd0);
    chk("t6_reads", 64'(rd_cnt - rd_base), 64'd0);

    // Reset during RUN, then a fresh run checks again from index 0.
    do_start(16'd5);
    wait_run();
    commit(0, PC_BASE);
    commit(1, PC_BASE + 32'd4);
    chk("t7_mid_count", 64'(count), 64'd2);
    rst = 1'b0;
    step();
    chk("t7_run", {63'd0, run}, 64'd0);
    chk("t7_done", {63'd0, done}, 64'd0);
    chk("t7_pass", {63'd0, pass}, 64'd0);
    chk("t7_count", 64'(count), 64'd0);
    chk("t7_grd", {63'd0, g_rd}, 64'd0);
    chk("t7_gaddr", 64'(g_addr), 64'd0);
    chk("t7_err", 64'(err_code), 64'd0);
    chk("t7_err_index", 64'(err_index), 64'd0);
    chk("t7_got_pc", 64'(err_got_pc), 64'd0);
    chk("t7_got_inst", 64'(err_got_inst), 64'd0);
    chk("t7_done2", {63'd0, done2}, 64'd0);
    rst = 1'b1;
    step();
    rd_base = rd_cnt;
    do_start(16'd5);
    wait_run();
    for (int k = 0; k < 5; k++) commit(k, PC_BASE + 32'(4 * k));
    chk("t7_rerun_pass", {63'd0, pass}, 64'd1);
    chk("t7_rerun_count", 64'(count), 64'd5);
    chk("t7_rerun_reads", 64'(rd_cnt - rd_base), 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_checker.md
# trace_checker

Golden-trace commit checker that sits directly downstream of the single-cycle CPU (`sccomp_dataflow`). It consumes the CPU's per-cycle commit stream and compares each commit against a golden trace held in an external synchronous ROM. The compared fields are the PC offset, the instruction and, optionally, the register write. It prefetches golden entries into a small FIFO and gates CPU execution through `run`. On the first divergence it stops with a captured error record.

## Interface
- `AW`, 16: golden ROM address width; also the width of `trace_len`, `count` and `err_index`.
- `DEPTH`, 4: prefetch FIFO depth; power of two, ≥2.
- `PC_BASE`, 32'h00400000: subtracted from `c_pc` before the PC comparison.
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-low.
- `start` in 1: pulse that begins a check run.
- `trace_len` in AW: number of golden entries; sampled on `start`.
- `g_rd` out 1: ROM read strobe.
- `g_addr` out AW: ROM address.
- `g_data` in GW: ROM data, valid exactly 1 cycle after `g_rd`.
  - GW = 64 without the macro; layout {pc,inst}.
  - GW = 102 with the macro; layout {pc,inst,we,waddr[4:0],wdata}.
- `c_valid` in 1: the CPU committed one instruction this cycle.
- `c_pc`, `c_inst`, `c_wdata` in 32 each: commit PC, instruction, write data.
- `c_we` in 1, `c_waddr` in 5: register-file write enable and address.
- `run` out 1: release for the CPU reset; the top drives CPU reset = ~run.
- `done` out 1: the check has finished.
- `pass` out 1: the check finished without error.
- `err_code` out 2: 0 none, 1 pc/inst mismatch, 2 register-write mismatch, 3 FIFO underflow.
- `err_index` out AW: golden index of the failing commit.
- `err_got_pc`, `err_got_inst` out 32: captured commit values.
- `count` out AW: number of commits checked and matched.

## Operation
- FSM states: IDLE, FILL, RUN, PASS, FAIL. Reset state is IDLE.
- `start` is accepted in IDLE, PASS or FAIL. It is ignored in FILL and RUN.
  - On acceptance, the block clears all counters, the FIFO and the error record, latches `trace_len`, and goes to FILL.
  - If `trace_len` = 0, it goes straight to PASS.
- Prefetch (FILL and RUN):
  - Assert `g_rd` with `g_addr` = issued while issued < len and occupancy + in_flight < DEPTH.
  - Returning data is written to the FIFO one cycle later.
  - `issued` increments on every `g_rd`.
- FILL → RUN when occupancy ≥ 2 or every entry is buffered (occupancy = len).
- `run` = 1 only in RUN.
- RUN, per cycle with `c_valid` = 1:
  - If the FIFO is empty: err 3.
  - Else if c_pc−PC_BASE ≠ head.pc or c_inst ≠ head.inst: err 1.
  - Else, macro only, if the effective writes differ: err 2. Effective write = we && waddr≠0. When both sides write, waddr and wdata must also match.
  - Priority is 3 > 1 > 2.
  - On a match: pop the head and increment `count`. When `count` reaches len → PASS.
  - On an error: capture `err_index` = count, `err_got_pc` = raw `c_pc`, `err_got_inst`; then → FAIL.
- `c_valid` is ignored outside RUN.
- ROM data still in flight when the FSM leaves RUN or FILL is discarded.
- PASS: `done` = 1, `pass` = 1. FAIL: `done` = 1, `pass` = 0.
- Arithmetic: PC subtraction is modulo 2^32. Counters never wrap, because they stop at len.

## Timing
- Reset values: all outputs 0, `g_addr` = 0.
- Read latency: `g_rd` at cycle t → `g_data` sampled at t+1 → FIFO entry usable at t+2.
- Sustained throughput: one check per cycle with no underflow once RUN is entered.
- Status update: `done`, `pass`, `err_*`, `count` and the state change are registered. They change in the cycle after the deciding commit.
  - `run` drops in that same cycle.
  - A commit arriving in the cycle of the drop is ignored.
- Simultaneous events:
  - FIFO push and pop in the same cycle leave occupancy unchanged.
  - Error and final commit in the same cycle → FAIL.
- Reset during any state → IDLE on the next edge.
  - An in-flight read is discarded.
  - `run` = 0 holds the CPU in reset.

## Configuration
- `TRACE_CHECK_REGWRITE_EN` defined:
  - GW = 102.
  - The register-write comparison and err 2 are active.
- `TRACE_CHECK_REGWRITE_EN` undefined:
  - GW = 64.
  - `c_we`, `c_waddr` and `c_wdata` are unused.
  - err 2 is never produced.

## Test plan
- Matching trace: len=5, ROM pc 0,4,8,C,10, and the CPU replays them one per cycle. Required: `pass`=1, `count`=5, `done` 1 cycle after the 5th commit, `g_rd` seen exactly 5 times.
- PC divergence: the 3rd commit has `c_pc`=00400010 where golden is 8. Required: `err_code`=1, `err_index`=2, `err_got_pc`=00400010, `count`=2, `run` falls the next cycle.
- Register-write mismatch (macro on): golden {we=1,waddr=8,wdata=5}, commit wdata=6. Required: `err_code`=2. The same case with waddr=0 on both sides and differing wdata must still pass.
- Underflow: ROM stalled by forcing len=3 while `c_valid` is held high for 4 cycles. Required: `pass`=1 after 3 commits and the 4th commit ignored. A separate forced-empty FIFO case with `c_valid` high must give `err_code`=3.
- `trace_len`=0: `start` → PASS the next cycle, `run` never asserts, no `g_rd`.
- Reset mid-RUN after 2 commits: `rst`=0 for one cycle. Required: all outputs 0, state IDLE, a fresh `start` rechecks from index 0.
